// File: rtl/dut_output_channel_control_if.sv
// ============================================================================
// Module      : dut_output_channel_control_if
// Description : Arbiter-side and output-side handshake bundle for the output
//               channel controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dut_output_channel_control_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  arb_out_valid;
    logic [DATA_WIDTH-1:0] arb_out_data;
    logic                  arb_out_data_last;
    logic                  out_ready_arb;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_data_last;

    // Channel controller view
    modport slave (
        input  arb_out_valid, arb_out_data, arb_out_data_last, out_ready,
        output out_ready_arb, out_valid, out_data, out_data_last
    );

    // Environment view: arbiter source plus output sink
    modport master (
        output arb_out_valid, arb_out_data, arb_out_data_last, out_ready,
        input  out_ready_arb, out_valid, out_data, out_data_last
    );
endinterface

`default_nettype wire

// File: rtl/dut_output_channel_control.sv
// ============================================================================
// Module      : dut_output_channel_control
// Description : Output channel controller with a two-entry skid buffer, last-
//               beat blocking, delivered-beat counter and frame-done flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dut_output_channel_control #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  wire logic                 clk,
    input  wire logic                 nreset,
    input  wire logic                 first_cycle_of_proc_req,
    input  wire logic                 out_en,
    dut_output_channel_control_if.slave bus,
    output logic                      frame_done,
    output logic [CNT_WIDTH-1:0]      beat_cnt,
    input  wire logic                 VDD,
    input  wire logic                 VSS
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                  r_main_v;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic                  r_main_last;
    logic                  r_skid_v;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_last;
    logic                  r_last_acc;
    logic                  r_frame_done;
    logic [CNT_WIDTH-1:0]  r_beat_cnt;

    logic w_out_ready_arb;
    logic w_arb_xfer;
    logic w_out_xfer;
    logic w_unused_power;

    assign w_unused_power = VDD ^ VSS;

    // Ready is built only from registers and side inputs so the sink's ready
    // never reaches the arbiter combinationally.
    assign w_out_ready_arb = !first_cycle_of_proc_req && out_en && !r_last_acc && !r_skid_v;
    assign w_arb_xfer      = bus.arb_out_valid && w_out_ready_arb;
    assign w_out_xfer      = r_main_v && bus.out_ready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_main_v    <= 1'b0;
            r_main_data <= '0;
            r_main_last <= 1'b0;
        end else if (first_cycle_of_proc_req) begin
            r_main_v    <= 1'b0;
        end else if (w_out_xfer && r_skid_v) begin
            r_main_v    <= 1'b1;
            r_main_data <= r_skid_data;
            r_main_last <= r_skid_last;
        end else if (w_arb_xfer && (!r_main_v || w_out_xfer)) begin
            r_main_v    <= 1'b1;
            r_main_data <= bus.arb_out_data;
            r_main_last <= bus.arb_out_data_last;
        end else if (w_out_xfer) begin
            r_main_v    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_skid_v    <= 1'b0;
            r_skid_data <= '0;
            r_skid_last <= 1'b0;
        end else if (first_cycle_of_proc_req) begin
            r_skid_v    <= 1'b0;
        end else if (w_arb_xfer && r_main_v && !w_out_xfer) begin
            r_skid_v    <= 1'b1;
            r_skid_data <= bus.arb_out_data;
            r_skid_last <= bus.arb_out_data_last;
        end else if (w_out_xfer) begin
            r_skid_v    <= 1'b0;
        end
    end

    // Frame bookkeeping: last-accepted blocking, completion flag, beat count
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_last_acc   <= 1'b0;
            r_frame_done <= 1'b0;
            r_beat_cnt   <= '0;
        end else if (first_cycle_of_proc_req) begin
            r_last_acc   <= 1'b0;
            r_frame_done <= 1'b0;
            r_beat_cnt   <= '0;
        end else begin
            if (w_arb_xfer && bus.arb_out_data_last) begin
                r_last_acc <= 1'b1;
            end
            if (w_out_xfer && r_main_last) begin
                r_frame_done <= 1'b1;
            end
            if (w_out_xfer && (r_beat_cnt != C_CNT_MAX)) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    assign bus.out_ready_arb = w_out_ready_arb;
    assign bus.out_valid     = r_main_v;
    assign bus.out_data      = r_main_data;
    assign bus.out_data_last = r_main_last;
    assign frame_done        = r_frame_done;
    assign beat_cnt          = r_beat_cnt;

endmodule

`default_nettype wire
